// File: rtl/cable_pkg.sv
// Shared types and screen constants for the cable launch/collision control slice.
package cable_pkg;

   localparam int unsigned COORD_W       = 11;
   localparam int unsigned SCREEN_X_LAST = 639;
   localparam int unsigned SCREEN_Y_LAST = 479;
   localparam int unsigned OBJ_SIZE      = 64;

   localparam logic signed [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_X_LAST - OBJ_SIZE);
   localparam logic signed [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_Y_LAST - OBJ_SIZE);

   typedef enum logic [1:0] {
      HOME    = 2'd0,
      EXTEND  = 2'd1,
      RETRACT = 2'd2
   } cable_state_t;

   typedef enum logic [1:0] {
      NONE     = 2'd0,
      GOLD     = 2'd1,
      ROCK     = 2'd2,
      EDGE_TMO = 2'd3
   } hit_t;

   typedef struct packed {
      logic gold;
      logic rock;
      logic edge_hit;
   } hit_flags_t;

   // Highest-priority hit wins: gold, then rock, then edge.
   function automatic hit_t prio_hit(input hit_flags_t f);
      if (f.gold)     return GOLD;
      if (f.rock)     return ROCK;
      if (f.edge_hit) return EDGE_TMO;
      return NONE;
   endfunction

   // Hook top-left outside the legal drawing area (signed compare).
   function automatic logic out_of_bounds(input logic signed [COORD_W-1:0] x,
                                          input logic signed [COORD_W-1:0] y);
      return x[COORD_W-1] | y[COORD_W-1] | (x > X_MAX) | (y > Y_MAX);
   endfunction

endpackage

// File: rtl/cable_launch_ctrl_if.sv
// Frame, hook/object overlap inputs and launch/collision/grab outputs of the cable controller.
interface cable_launch_ctrl_if import cable_pkg::*; ();

   logic                       startOfFrame;
   logic                       keyLaunch;
   logic                       IsInCircular;
   logic signed [COORD_W-1:0]  hookTopLeftX;
   logic signed [COORD_W-1:0]  hookTopLeftY;
   logic                       hookDR;
   logic                       goldDR;
   logic                       rockDR;
   logic                       launch_Cable;
   logic                       collision;
   hit_t                       hitType;
   logic                       grabDone;
   cable_state_t               cableState;

   modport slave (
      input  startOfFrame, keyLaunch, IsInCircular, hookTopLeftX, hookTopLeftY,
             hookDR, goldDR, rockDR,
      output launch_Cable, collision, hitType, grabDone, cableState
   );

   modport master (
      output startOfFrame, keyLaunch, IsInCircular, hookTopLeftX, hookTopLeftY,
             hookDR, goldDR, rockDR,
      input  launch_Cable, collision, hitType, grabDone, cableState
   );

endinterface

// File: rtl/key_debouncer.sv
// Frame-rate key debouncer: accepts a new level after DEBOUNCE_FRAMES consecutive equal samples.
module key_debouncer #(
   parameter int unsigned DEBOUNCE_FRAMES = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic startOfFrame,
   input  logic keyIn,
   output logic keyStable,
   output logic keyPress
);

   localparam int unsigned CNT_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;

   logic [CNT_W-1:0] diff_cnt_q;

   // diff_cnt_q counts consecutive frame samples that disagree with keyStable.
   always_ff @(posedge clk) begin
      if (reset) begin
         keyStable  <= 1'b0;
         keyPress   <= 1'b0;
         diff_cnt_q <= '0;
      end else begin
         keyPress <= 1'b0;
         if (startOfFrame) begin
            if (keyIn == keyStable) begin
               diff_cnt_q <= '0;
            end else if (diff_cnt_q == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
               keyStable  <= keyIn;
               keyPress   <= keyIn;
               diff_cnt_q <= '0;
            end else begin
               diff_cnt_q <= diff_cnt_q + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/cable_launch_ctrl.sv
// Launch/collision/grab sequencing for the hook cable: one launch, one collision, one grabDone per throw.
module cable_launch_ctrl import cable_pkg::*; #(
   parameter int unsigned DEBOUNCE_FRAMES    = 3,
   parameter int unsigned MAX_EXTEND_FRAMES  = 90,
   parameter int unsigned MIN_RETRACT_FRAMES = 4
) (
   input  logic               clk,
   input  logic               reset,
   cable_launch_ctrl_if.slave bus
);

   localparam int unsigned FCNT_W = $clog2(MAX_EXTEND_FRAMES + 1);

   cable_state_t      state_q, state_nxt;
   hit_flags_t        latch_q, hits_now;
   hit_t              hit_type_q, hit_type_c;
   logic [FCNT_W-1:0] fcnt_q;
   logic              key_stable, key_press;
   logic              hit_any, timeout_c, retract_done_c;
   logic              launch_c, collision_c, grab_c;
   logic              launch_q, collision_q, grab_q;

   key_debouncer #(
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
   ) u_key_debouncer (
      .clk          (clk),
      .reset        (reset),
      .startOfFrame (bus.startOfFrame),
      .keyIn        (bus.keyLaunch),
      .keyStable    (key_stable),
      .keyPress     (key_press)
   );

   always_comb begin
      hits_now          = '0;
      hits_now.gold     = bus.hookDR & bus.goldDR;
      hits_now.rock     = bus.hookDR & bus.rockDR;
      hits_now.edge_hit = out_of_bounds(bus.hookTopLeftX, bus.hookTopLeftY);
   end

   assign hit_any        = latch_q.gold | latch_q.rock | latch_q.edge_hit;
   assign timeout_c      = (fcnt_q == FCNT_W'(MAX_EXTEND_FRAMES - 1));
   assign retract_done_c = (fcnt_q >= FCNT_W'(MIN_RETRACT_FRAMES)) & bus.IsInCircular;

   always_ff @(posedge clk) begin
      if (reset) state_q <= HOME;
      else       state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         HOME:    if (key_press && key_stable && bus.IsInCircular) state_nxt = EXTEND;
         EXTEND:  if (bus.startOfFrame && (hit_any || timeout_c)) state_nxt = RETRACT;
         RETRACT: if (retract_done_c) state_nxt = HOME;
         default: state_nxt = HOME;
      endcase
   end

   // Pulses are raised only on the transition out of each state, so they can never overlap.
   always_comb begin
      launch_c    = 1'b0;
      collision_c = 1'b0;
      grab_c      = 1'b0;
      hit_type_c  = hit_type_q;
      case (state_q)
         HOME: if (state_nxt == EXTEND) begin
            launch_c   = 1'b1;
            hit_type_c = NONE;
         end
         EXTEND: if (state_nxt == RETRACT) begin
            collision_c = 1'b1;
            hit_type_c  = hit_any ? prio_hit(latch_q) : EDGE_TMO;
         end
         RETRACT: if (state_nxt == HOME) grab_c = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         launch_q    <= 1'b0;
         collision_q <= 1'b0;
         grab_q      <= 1'b0;
         hit_type_q  <= NONE;
      end else begin
         launch_q    <= launch_c;
         collision_q <= collision_c;
         grab_q      <= grab_c;
         hit_type_q  <= hit_type_c;
      end
   end

   // Shared frame counter: extend timeout, then retract dwell (saturating).
   always_ff @(posedge clk) begin
      if (reset || launch_c || collision_c) begin
         fcnt_q <= '0;
      end else if (bus.startOfFrame && state_q == EXTEND) begin
         fcnt_q <= fcnt_q + FCNT_W'(1);
      end else if (bus.startOfFrame && state_q == RETRACT &&
                   fcnt_q < FCNT_W'(MIN_RETRACT_FRAMES)) begin
         fcnt_q <= fcnt_q + FCNT_W'(1);
      end
   end

   // A hit coinciding with startOfFrame lands in the freshly cleared latch.
   always_ff @(posedge clk) begin
      if (reset || state_q != EXTEND) latch_q <= '0;
      else if (bus.startOfFrame)      latch_q <= hits_now;
      else                            latch_q <= hit_flags_t'(latch_q | hits_now);
   end

   assign bus.launch_Cable = launch_q;
   assign bus.collision    = collision_q;
   assign bus.grabDone     = grab_q;
   assign bus.hitType      = hit_type_q;
   assign bus.cableState   = state_q;

endmodule

// File: tb/tb_cable_launch_ctrl.sv
// Bench for cable_launch_ctrl: vector table, directed throw scenarios, randomized run vs. reference model.
module tb_cable_launch_ctrl;

   localparam int D    = 3;
   localparam int MAXF = 90;
   localparam int MINR = 4;
   localparam int XM   = 639 - 64;
   localparam int YM   = 479 - 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cable_launch_ctrl_if bus ();
   cable_launch_ctrl dut (.clk(clk), .reset(rst), .bus(bus));

   int checks = 0, errors = 0;
   int n_launch = 0, n_coll = 0, n_grab = 0;

   // Reference model: throw phase 0=home 1=extend 2=retract, plain counters and a sample queue
   bit m_q[$];
   bit m_stable = 0, m_press = 0;
   int m_phase = 0, m_frames = 0, m_ret = 0;
   bit m_g = 0, m_r = 0, m_e = 0;
   bit e_l = 0, e_c = 0, e_g = 0;
   int e_h = 0;

   typedef struct {
      bit rst, sof, key, circ, hdr, gdr, rdr;
      bit l, c, g;
      int ht, st;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(bit r, bit s, bit k, bit ci, bit h, bit g, bit ro,
                               bit l, bit co, bit gr, int ht, int st);
      vec_t v;
      v.rst = r; v.sof = s; v.key = k; v.circ = ci; v.hdr = h; v.gdr = g; v.rdr = ro;
      v.l = l; v.c = co; v.g = gr; v.ht = ht; v.st = st;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit sof, circ, ng, nr, ne;
      int xi, yi;
      bit all_eq;
      sof  = bus.startOfFrame;
      circ = bus.IsInCircular;
      xi   = int'(bus.hookTopLeftX);
      yi   = int'(bus.hookTopLeftY);
      ng   = bus.hookDR & bus.goldDR;
      nr   = bus.hookDR & bus.rockDR;
      ne   = (xi < 0) || (xi > XM) || (yi < 0) || (yi > YM);
      if (rst) begin
         m_q.delete(); m_stable = 0; m_press = 0;
         m_phase = 0; m_frames = 0; m_ret = 0; m_g = 0; m_r = 0; m_e = 0;
         e_l = 0; e_c = 0; e_g = 0; e_h = 0;
         return;
      end
      e_l = 0; e_c = 0; e_g = 0;
      if (m_phase == 0) begin
         if (m_press && circ) begin
            e_l = 1; m_phase = 1; m_frames = 0; e_h = 0;
            m_g = 0; m_r = 0; m_e = 0;
         end
      end else if (m_phase == 1) begin
         if (sof) begin
            if (m_g || m_r || m_e) begin
               e_c = 1;
               e_h = m_g ? 1 : (m_r ? 2 : 3);
            end else if (m_frames == MAXF - 1) begin
               e_c = 1; e_h = 3;
            end else begin
               m_frames++;
            end
            m_g = 0; m_r = 0; m_e = 0;
         end
         m_g |= ng; m_r |= nr; m_e |= ne;
         if (e_c) begin m_phase = 2; m_ret = 0; end
      end else begin
         if (m_ret >= MINR && circ) begin
            e_g = 1; m_phase = 0;
         end else if (sof) begin
            m_ret++;
         end
      end
      m_press = 0;
      if (sof) begin
         m_q.push_back(bus.keyLaunch);
         if (m_q.size() > D) void'(m_q.pop_front());
         if (m_q.size() == D) begin
            all_eq = 1;
            foreach (m_q[i]) if (m_q[i] != m_q[0]) all_eq = 0;
            if (all_eq && m_q[0] != m_stable) begin
               m_stable = m_q[0];
               m_press  = m_stable;
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      n_launch += int'(bus.launch_Cable);
      n_coll   += int'(bus.collision);
      n_grab   += int'(bus.grabDone);
      chk("model_launch", int'(bus.launch_Cable), int'(e_l));
      chk("model_collision", int'(bus.collision), int'(e_c));
      chk("model_grab", int'(bus.grabDone), int'(e_g));
      chk("model_hitType", int'(bus.hitType), e_h);
      chk("model_state", int'(bus.cableState), m_phase);
   endtask

   task automatic frame();
      bus.startOfFrame = 1'b1; tick();
      bus.startOfFrame = 1'b0; tick(); tick();
   endtask

   task automatic sof_tick();
      bus.startOfFrame = 1'b1; tick();
      bus.startOfFrame = 1'b0;
   endtask

   task automatic clear_hits();
      bus.hookDR = 1'b0; bus.goldDR = 1'b0; bus.rockDR = 1'b0;
      bus.hookTopLeftX = 11'sd100; bus.hookTopLeftY = 11'sd100;
   endtask

   task automatic launch_seq(input string name);
      int nl;
      bus.IsInCircular = 1'b1;
      bus.keyLaunch = 1'b0;
      repeat (D) frame();
      bus.keyLaunch = 1'b1;
      nl = n_launch;
      repeat (D) sof_tick();
      for (int i = 0; i < 8 && n_launch == nl; i++) tick();
      chk({name, "_launch"}, n_launch - nl, 1);
      chk({name, "_extend"}, int'(bus.cableState), 1);
   endtask

   task automatic wait_home(input string name);
      bus.IsInCircular = 1'b1;
      clear_hits();
      for (int i = 0; i < 120 && int'(bus.cableState) != 0; i++) frame();
      chk({name, "_home"}, int'(bus.cableState), 0);
   endtask

   function automatic int pick_coord(input int lim);
      int r;
      r = int'($urandom_range(0, 999));
      if (r == 0) return -1;
      if (r == 1) return lim + 1;
      if (r == 2) return lim;
      if (r == 3) return 0;
      return int'($urandom_range(1, lim - 1));
   endfunction

   initial begin
      int nl, nc, ng, gf;
      bit quiet;
      bus.startOfFrame = 1'b0; bus.keyLaunch = 1'b0; bus.IsInCircular = 1'b1;
      clear_hits();

      // rst sof key circ hdr gdr rdr | launch coll grab hitType state
      tbl.push_back(mk(1,0,0,1,0,0,0, 0,0,0,0,0));
      repeat (3) tbl.push_back(mk(0,1,1,1,0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(0,0,1,1,0,0,0, 1,0,0,0,1));
      tbl.push_back(mk(0,0,1,1,1,1,0, 0,0,0,0,1));
      tbl.push_back(mk(0,1,1,1,0,0,0, 0,1,0,1,2));
      repeat (3) tbl.push_back(mk(0,1,1,1,0,0,0, 0,0,0,1,2));
      tbl.push_back(mk(0,1,1,0,0,0,0, 0,0,0,1,2));
      tbl.push_back(mk(0,0,1,0,0,0,0, 0,0,0,1,2));
      tbl.push_back(mk(0,0,1,1,0,0,0, 0,0,1,1,0));
      tbl.push_back(mk(0,0,1,1,0,0,0, 0,0,0,1,0));
      repeat (3) tbl.push_back(mk(0,1,0,1,0,0,0, 0,0,0,1,0));
      repeat (3) tbl.push_back(mk(0,1,1,0,0,0,0, 0,0,0,1,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 0,0,0,1,0));
      tbl.push_back(mk(0,0,1,1,0,0,0, 0,0,0,1,0));

      foreach (tbl[i]) begin
         rst = tbl[i].rst;
         bus.startOfFrame = tbl[i].sof; bus.keyLaunch = tbl[i].key;
         bus.IsInCircular = tbl[i].circ; bus.hookDR = tbl[i].hdr;
         bus.goldDR = tbl[i].gdr; bus.rockDR = tbl[i].rdr;
         tick();
         chk($sformatf("tbl%0d_launch", i), int'(bus.launch_Cable), int'(tbl[i].l));
         chk($sformatf("tbl%0d_coll", i), int'(bus.collision), int'(tbl[i].c));
         chk($sformatf("tbl%0d_grab", i), int'(bus.grabDone), int'(tbl[i].g));
         chk($sformatf("tbl%0d_hit", i), int'(bus.hitType), tbl[i].ht);
         chk($sformatf("tbl%0d_state", i), int'(bus.cableState), tbl[i].st);
      end
      rst = 1'b0;
      bus.startOfFrame = 1'b0;
      clear_hits();

      // Held key gives one launch; then a full unhit extension times out on frame 90
      launch_seq("t1");
      nl = n_launch;
      repeat (20) frame();
      chk("t1_no_relaunch", n_launch - nl, 0);
      chk("t1_still_extend", int'(bus.cableState), 1);
      nc = n_coll;
      repeat (MAXF - 21) frame();
      chk("t4_no_early_tmo", n_coll - nc, 0);
      sof_tick();
      chk("t4_tmo_coll", int'(bus.collision), 1);
      chk("t4_tmo_hit", int'(bus.hitType), 3);
      chk("t4_retract", int'(bus.cableState), 2);
      ng = n_grab; gf = 0;
      for (int f = 1; f <= 6; f++) begin
         frame();
         if (gf == 0 && n_grab != ng) gf = f;
      end
      chk("t4_grab_frame", gf, MINR);
      chk("t4_grab_count", n_grab - ng, 1);
      chk("t4_home", int'(bus.cableState), 0);
      chk("t4_hit_hold", int'(bus.hitType), 3);

      // Gold overlap mid-frame
      launch_seq("t2");
      tick();
      bus.hookDR = 1'b1; bus.goldDR = 1'b1; tick();
      clear_hits(); tick();
      chk("t2_no_early_coll", int'(bus.collision), 0);
      sof_tick();
      chk("t2_coll", int'(bus.collision), 1);
      chk("t2_hit_gold", int'(bus.hitType), 1);
      chk("t2_retract", int'(bus.cableState), 2);
      wait_home("t2");

      // Gold and rock in one frame: gold wins
      launch_seq("t3");
      bus.hookDR = 1'b1; bus.goldDR = 1'b1; tick();
      bus.goldDR = 1'b0; bus.rockDR = 1'b1; tick();
      clear_hits();
      sof_tick();
      chk("t3_gold_wins", int'(bus.hitType), 1);
      wait_home("t3");

      launch_seq("t3r");
      bus.hookDR = 1'b1; bus.rockDR = 1'b1; tick();
      clear_hits();
      sof_tick();
      chk("t3r_hit_rock", int'(bus.hitType), 2);
      wait_home("t3r");

      launch_seq("t3e");
      bus.hookTopLeftX = -11'sd3; tick();
      clear_hits();
      sof_tick();
      chk("t3e_coll", int'(bus.collision), 1);
      chk("t3e_hit_edge", int'(bus.hitType), 3);
      wait_home("t3e");

      // Exact edge limits are legal, one past is not
      launch_seq("t3b");
      bus.hookTopLeftX = 11'(XM); bus.hookTopLeftY = 11'(YM);
      tick(); tick();
      sof_tick();
      chk("t3b_limit_legal", int'(bus.collision), 0);
      chk("t3b_limit_extend", int'(bus.cableState), 1);
      bus.hookTopLeftX = 11'(XM + 1); tick();
      clear_hits();
      sof_tick();
      chk("t3b_over_coll", int'(bus.collision), 1);
      chk("t3b_over_hit", int'(bus.hitType), 3);
      wait_home("t3b");

      // Hit coinciding with startOfFrame counts for the next frame
      launch_seq("t5");
      bus.startOfFrame = 1'b1; bus.hookDR = 1'b1; bus.goldDR = 1'b1; tick();
      bus.startOfFrame = 1'b0; clear_hits();
      chk("t5_same_cycle_no_coll", int'(bus.collision), 0);
      chk("t5_still_extend", int'(bus.cableState), 1);
      tick();
      sof_tick();
      chk("t5_next_frame_coll", int'(bus.collision), 1);
      chk("t5_hit_gold", int'(bus.hitType), 1);

      // Reset during RETRACT, then a press while not at home is dropped
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t6_state", int'(bus.cableState), 0);
      chk("t6_launch", int'(bus.launch_Cable), 0);
      chk("t6_coll", int'(bus.collision), 0);
      chk("t6_grab", int'(bus.grabDone), 0);
      chk("t6_hit", int'(bus.hitType), 0);
      bus.keyLaunch = 1'b1; bus.IsInCircular = 1'b0;
      nl = n_launch;
      repeat (D + 2) frame();
      chk("t6_no_launch_away", n_launch - nl, 0);
      bus.IsInCircular = 1'b1;
      repeat (3) frame();
      chk("t6_press_not_queued", n_launch - nl, 0);
      chk("t6_home", int'(bus.cableState), 0);

      // Randomized run against the reference model
      rst = 1'b1; tick(); rst = 1'b0;
      quiet = 1'b0;
      for (int c = 0; c < 30000; c++) begin
         if (c % 2000 == 0) quiet = ~quiet;
         bus.startOfFrame = (c % 6 == 0);
         if (c % 6 == 0 && $urandom_range(0, 5) == 0) bus.keyLaunch = ~bus.keyLaunch;
         bus.IsInCircular = ($urandom_range(0, 9) < 7);
         bus.hookDR = !quiet && ($urandom_range(0, 19) == 0);
         bus.goldDR = ($urandom_range(0, 19) == 0);
         bus.rockDR = ($urandom_range(0, 19) == 0);
         if (quiet) begin
            bus.hookTopLeftX = 11'sd200; bus.hookTopLeftY = 11'sd200;
         end else begin
            bus.hookTopLeftX = 11'(pick_coord(XM));
            bus.hookTopLeftY = 11'(pick_coord(YM));
         end
         rst = ($urandom_range(0, 2999) == 0);
         tick();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
